mem_access_unit: RTL

- Memory stage of the 5-stage pipelined MIPS.
- Sits between the EX/M pipeline register and the M/WB pipeline register.
- Accepts a load/store from the M stage and runs a req/ack handshake to data memory.
- Stalls the pipeline until the access completes, then presents ReadDataM and a gated RegWriteM to the M/WB register.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mau_wait_counter.sv | 34 +++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS pipeline memory stage
// Purpose: FSM state encoding for the memory access unit and the word-alignment mask.
// Ports: none (package).
package mips_pkg;

  // Memory access unit FSM encoding
  localparam logic [1:0] MAU_IDLE = 2'd0;
  localparam logic [1:0] MAU_BUSY = 2'd1;
  localparam logic [1:0] MAU_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MAU_IDLE,
    ST_BUSY = MAU_BUSY,
    ST_DONE = MAU_DONE
  } mau_state_t;

  // Byte-offset bits that must be zero for a word access
  localparam logic [1:0] MAU_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mau_wait_counter.sv
// rtl/mau_wait_counter.sv - bounded wait counter for outstanding memory requests
// Purpose: counts cycles spent waiting for a memory acknowledge.
// Ports:
//   MAU_CLK  in  clock, rising edge
//   MAU_RST  in  synchronous active-high reset
//   cnt_clr  in  synchronous clear (wins over enable)
//   cnt_en   in  count enable
//   cnt_tc   out terminal count, high while the count equals TIMEOUT-1
module mau_wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic MAU_CLK,
  input  logic MAU_RST,
  input  logic cnt_clr,
  input  logic cnt_en,
  output logic cnt_tc
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  assign cnt_tc = (cnt == CW'(TIMEOUT - 1));

  // Holds at terminal count so a stray enable can never wrap back to zero
  always_ff @(posedge MAU_CLK) begin
    if (MAU_RST || cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en && !cnt_tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MIPS memory stage: load/store handshake with pipeline stall
// Purpose: issues a registered req/ack access to data memory for a load or store in
// the M stage, stalls the earlier pipeline stages until it completes, and presents
// the load result plus a bubble-gated register write to the M/WB register.
// Ports:
//   MAU_CLK, MAU_RST            clock, synchronous active-high reset
//   MAU_AluOutM, MAU_WriteDataM byte address and store data from EX/M
//   MAU_MemReadM, MAU_MemWriteM load / store in M (both high = store)
//   MAU_RegWriteM               register-write control from EX/M
//   MAU_MemRdata, MAU_MemAck    data-memory read data and one-cycle completion
//   MAU_MemReq, MAU_MemWe       registered request and write enable
//   MAU_MemAddr, MAU_MemWdata   registered word address and store data
//   MAU_ReadDataM               load result (valid in the completion cycle)
//   MAU_RegWriteOutM            MAU_RegWriteM gated off while stalled
//   MAU_StallM                  freeze PC, F/D, D/E and EX/M
//   MAU_AlignErr, MAU_BusErr    misalignment pulse, sticky timeout flag
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             MAU_CLK,
  input  logic             MAU_RST,
  input  logic [WIDTH-1:0] MAU_AluOutM,
  input  logic [WIDTH-1:0] MAU_WriteDataM,
  input  logic             MAU_MemReadM,
  input  logic             MAU_MemWriteM,
  input  logic             MAU_RegWriteM,
  input  logic [WIDTH-1:0] MAU_MemRdata,
  input  logic             MAU_MemAck,
  output logic             MAU_MemReq,
  output logic             MAU_MemWe,
  output logic [WIDTH-1:0] MAU_MemAddr,
  output logic [WIDTH-1:0] MAU_MemWdata,
  output logic [WIDTH-1:0] MAU_ReadDataM,
  output logic             MAU_RegWriteOutM,
  output logic             MAU_StallM,
  output logic             MAU_AlignErr,
  output logic             MAU_BusErr
);

  mau_state_t state, state_next;

  logic             access;
  logic             misaligned;
  logic             stall;
  logic             start_req;
  logic             take_ack;
  logic             take_timeout;
  logic             take_misalign;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [WIDTH-1:0] hold_q;
  logic             align_err_q;
  logic             bus_err_q;

  assign access     = MAU_MemReadM | MAU_MemWriteM;
  assign misaligned = |(MAU_AluOutM[1:0] & MAU_ALIGN_MASK);

  mau_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .MAU_CLK (MAU_CLK),
    .MAU_RST (MAU_RST),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en),
    .cnt_tc  (cnt_tc)
  );

  always_ff @(posedge MAU_CLK) begin
    if (MAU_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    start_req     = 1'b0;
    take_ack      = 1'b0;
    take_timeout  = 1'b0;
    take_misalign = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (misaligned) begin
            take_misalign = 1'b1;
            state_next    = ST_DONE;
          end else begin
            start_req  = 1'b1;
            cnt_clr    = 1'b1;
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // An ack arriving in the terminal-count cycle still completes the access
        if (MAU_MemAck) begin
          take_ack   = 1'b1;
          state_next = ST_DONE;
        end else if (cnt_tc) begin
          take_timeout = 1'b1;
          state_next   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // The pipeline must never freeze while the unit is being reset
    if (MAU_RST) begin
      stall = 1'b0;
    end
  end

  always_ff @(posedge MAU_CLK) begin
    if (MAU_RST) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= 1'b0;
      if (start_req) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= MAU_MemWriteM;
        mem_addr_q  <= MAU_AluOutM & ~{{(WIDTH-2){1'b0}}, MAU_ALIGN_MASK};
        mem_wdata_q <= MAU_WriteDataM;
      end
      if (take_ack) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        hold_q    <= mem_we_q ? '0 : MAU_MemRdata;
      end
      if (take_timeout) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        bus_err_q <= 1'b1;
        hold_q    <= '0;
      end
      if (take_misalign) begin
        align_err_q <= 1'b1;
        hold_q      <= '0;
      end
    end
  end

  assign MAU_MemReq       = mem_req_q;
  assign MAU_MemWe        = mem_we_q;
  assign MAU_MemAddr      = mem_addr_q;
  assign MAU_MemWdata     = mem_wdata_q;
  assign MAU_ReadDataM    = hold_q;
  assign MAU_StallM       = stall;
  assign MAU_RegWriteOutM = MAU_RegWriteM & ~stall;
  assign MAU_AlignErr     = align_err_q;
  assign MAU_BusErr       = bus_err_q;

endmodule
